// File: rtl/seq_gen_pkg.sv
// rtl/seq_gen_pkg.sv - state encoding and constants for seq_gen_1010 (PRE state under SEQ_GEN_PREAMBLE_EN)
package seq_gen_pkg;

    localparam int         PRE_LEN         = 2;
    localparam logic [3:0] DEFAULT_PATTERN = 4'b1010;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_SHIFT = 2'd1;
    localparam logic [1:0] ENC_DONE  = 2'd2;
    localparam logic [1:0] ENC_PRE   = 2'd3;

`ifdef SEQ_GEN_PREAMBLE_EN
    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_SHIFT = ENC_SHIFT,
        ST_DONE  = ENC_DONE,
        ST_PRE   = ENC_PRE
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = ENC_IDLE,
        ST_SHIFT = ENC_SHIFT,
        ST_DONE  = ENC_DONE
    } state_t;
`endif

endpackage

// File: rtl/seq_gen_1010_if.sv
// rtl/seq_gen_1010_if.sv - request/serial-output bundle between a requester and seq_gen_1010
interface seq_gen_1010_if
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
);

    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [CNT_W-1:0] reps;
    logic             out;
    logic             valid;
    logic             busy;
    logic             done;

    modport master (
        output start, pattern, reps,
        input  out, valid, busy, done
    );

    modport slave (
        input  start, pattern, reps,
        output out, valid, busy, done
    );

endinterface

// File: rtl/seq_gen_shreg.sv
// rtl/seq_gen_shreg.sv - loadable MSB-first shift register, falling-edge clocked
module seq_gen_shreg
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] data_q;

    // clear wins over load, load wins over shift; zeros fill from the LSB
    always_ff @(negedge clk) begin
        if (clr) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= din;
        end else if (shift) begin
            data_q <= data_q << 1;
        end
    end

    assign msb = data_q[WIDTH-1];

endmodule

// File: rtl/seq_gen_1010.sv
// rtl/seq_gen_1010.sv - repeated-frame serial pattern generator; SEQ_GEN_PREAMBLE_EN adds a 2-cycle idle preamble
module seq_gen_1010
    import seq_gen_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic          clk,
    input  logic          clr,
    seq_gen_1010_if.slave bus
);

    // largest transfer is WIDTH bits times the largest repetition count
    localparam int MAX_BITS = WIDTH * ((1 << CNT_W) - 1);
    localparam int TOT_W    = $clog2(MAX_BITS + 1);
    localparam int IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [TOT_W-1:0] left_q, left_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic             sh_load, sh_shift;
    logic [WIDTH-1:0] sh_din;
    logic             sh_msb;
    logic [TOT_W-1:0] total_bits;

`ifdef SEQ_GEN_PREAMBLE_EN
    localparam int PRE_W = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
    logic [PRE_W-1:0] pre_q, pre_d;
`endif

    assign total_bits = TOT_W'(WIDTH) * TOT_W'(bus.reps);

    // left_q counts bits still to follow the one on out; idx_q is that bit's position in its frame
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        left_d    = left_q;
        idx_d     = idx_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        sh_din    = '0;
`ifdef SEQ_GEN_PREAMBLE_EN
        pre_d     = pre_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start && (bus.reps != '0)) begin
                    pattern_d = bus.pattern;
                    left_d    = total_bits - 1'b1;
                    idx_d     = LAST_IDX;
`ifdef SEQ_GEN_PREAMBLE_EN
                    state_d   = ST_PRE;
                    pre_d     = PRE_W'(PRE_LEN - 1);
`else
                    state_d   = ST_SHIFT;
                    valid_d   = 1'b1;
                    sh_load   = 1'b1;
                    sh_din    = bus.pattern;
`endif
                end
            end
`ifdef SEQ_GEN_PREAMBLE_EN
            ST_PRE: begin
                if (pre_q == '0) begin
                    state_d = ST_SHIFT;
                    valid_d = 1'b1;
                    sh_load = 1'b1;
                    sh_din  = pattern_q;
                end else begin
                    pre_d = pre_q - 1'b1;
                end
            end
`endif
            ST_SHIFT: begin
                if (left_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    sh_load = 1'b1;
                    sh_din  = '0;
                end else begin
                    valid_d = 1'b1;
                    left_d  = left_q - 1'b1;
                    if (idx_q == '0) begin
                        sh_load = 1'b1;
                        sh_din  = pattern_q;
                        idx_d   = LAST_IDX;
                    end else begin
                        sh_shift = 1'b1;
                        idx_d    = idx_q - 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state and counters advance on the falling edge; clr aborts from any state
    always_ff @(negedge clk) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            left_q    <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
`ifdef SEQ_GEN_PREAMBLE_EN
            pre_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            left_q    <= left_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
`ifdef SEQ_GEN_PREAMBLE_EN
            pre_q     <= pre_d;
`endif
        end
    end

    // the shift register doubles as the out flop: it is zero whenever no frame bit is being sent
    seq_gen_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk   (clk),
        .clr   (clr),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (sh_din),
        .msb   (sh_msb)
    );

    assign bus.out   = sh_msb;
    assign bus.valid = valid_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_gen_1010.sv
// tb/tb_seq_gen_1010.sv - scoreboard bench for seq_gen_1010 with a frame-level reference model
module tb_seq_gen_1010;
    import seq_gen_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;
`ifdef SEQ_GEN_PREAMBLE_EN
    localparam int PRE = PRE_LEN;
`else
    localparam int PRE = 0;
`endif

    logic clk = 1'b0;
    logic clr;
    bit   mon_en;

    int tests;
    int fails;

    logic exp_bits[$];
    int   exp_done[$];

    int         det_count;
    int         det_len;
    logic [3:0] det_hist;

    seq_gen_1010_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    seq_gen_1010 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: samples on the rising edge, half a cycle after the DUT updates
    initial begin
        logic e;
        forever begin
            @(posedge clk);
            if (mon_en) begin
                if (bus.valid === 1'b1) begin
                    if (exp_bits.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_bit: got valid=1 out=%b expected no bit at %0t", bus.out, $time);
                    end else begin
                        e = exp_bits.pop_front();
                        check_bit("serial_bit", bus.out, e);
                        det_hist = {det_hist[2:0], bus.out};
                        det_len++;
                        if (det_len >= 4 && det_hist == 4'b1010) begin
                            det_count++;
                            det_len = 0;
                        end
                    end
                end else begin
                    check_bit("out_zero_when_invalid", bus.out, 1'b0);
                end
                if (bus.done === 1'b1) begin
                    if (exp_done.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_done: got done=1 expected 0 at %0t", $time);
                    end else begin
                        void'(exp_done.pop_front());
                        check_int("bits_left_at_done", exp_bits.size(), 0);
                        check_bit("valid_low_at_done", bus.valid, 1'b0);
                    end
                end
            end
        end
    end

    // one request: the model expands it into the expected bit stream plus one done token
    task automatic run_frame(input logic [WIDTH-1:0] pat, input int reps, input bit hold);
        bit seen_done;
        @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.pattern = pat;
        bus.reps    = CNT_W'(reps);
        for (int r = 0; r < reps; r++)
            for (int b = WIDTH - 1; b >= 0; b--)
                exp_bits.push_back(pat[b]);
        exp_done.push_back(reps);
        for (int c = 0; c <= PRE; c++) begin
            @(posedge clk);
            check_bit("busy_after_accept", bus.busy, 1'b1);
            check_bit("first_bit_latency", bus.valid, (c == PRE));
            #1;
            if (hold) begin
                bus.pattern = 4'b0110;
                bus.reps    = CNT_W'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end
        seen_done = 1'b0;
        for (int n = 0; n < WIDTH * reps + PRE + 10 && !seen_done; n++) begin
            @(posedge clk);
            if (bus.done === 1'b1) seen_done = 1'b1;
            #1;
            if (hold) begin
                bus.pattern = WIDTH'($urandom);
                bus.reps    = CNT_W'($urandom);
            end
        end
        check_bit("done_seen", seen_done, 1'b1);
        bus.start = 1'b0;
        check_int("expected_bits_drained", exp_bits.size(), 0);
        check_int("expected_done_drained", exp_done.size(), 0);
        @(posedge clk);
        check_bit("idle_after_done", bus.busy, 1'b0);
    endtask

    initial begin
        tests       = 0;
        fails       = 0;
        mon_en      = 1'b0;
        det_count   = 0;
        det_len     = 0;
        det_hist    = '0;
        clr         = 1'b1;
        bus.start   = 1'b0;
        bus.pattern = '0;
        bus.reps    = '0;

        // reset state
        repeat (3) @(posedge clk);
        check_bit("reset_out", bus.out, 1'b0);
        check_bit("reset_valid", bus.valid, 1'b0);
        check_bit("reset_busy", bus.busy, 1'b0);
        check_bit("reset_done", bus.done, 1'b0);
        #1;
        clr    = 1'b0;
        mon_en = 1'b1;

        // single 1010 frame
        run_frame(4'b1010, 1, 1'b0);

        // three back-to-back frames seen by a non-overlapping 1010 detector
        det_count = 0;
        det_len   = 0;
        run_frame(4'b1010, 3, 1'b0);
        check_int("detections_reps3", det_count, 3);

        // reps=0 request must be ignored
        @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.pattern = 4'b1010;
        bus.reps    = '0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            check_bit("reps0_busy", bus.busy, 1'b0);
            check_bit("reps0_valid", bus.valid, 1'b0);
            check_bit("reps0_done", bus.done, 1'b0);
        end
        #1;
        bus.start = 1'b0;

        // abort after the second bit of a reps=2 transfer
        @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.pattern = 4'b1010;
        bus.reps    = CNT_W'(2);
        for (int r = 0; r < 2; r++)
            for (int b = WIDTH - 1; b >= 0; b--)
                exp_bits.push_back(bus.pattern[b]);
        exp_done.push_back(2);
        for (int c = 0; c < PRE + 2; c++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        check_int("bits_before_abort", exp_bits.size(), 2 * WIDTH - 2);
        clr = 1'b1;
        exp_bits.delete();
        exp_done.delete();
        @(posedge clk);
        check_bit("abort_out", bus.out, 1'b0);
        check_bit("abort_valid", bus.valid, 1'b0);
        check_bit("abort_busy", bus.busy, 1'b0);
        check_bit("abort_done", bus.done, 1'b0);
        #1;
        clr = 1'b0;
        run_frame(4'b1010, 1, 1'b0);

        // start held high with pattern/reps churning during the transfer
        run_frame(4'b1010, 1, 1'b1);
        run_frame(4'b1010, 2, 1'b1);

        // largest repetition count
        run_frame(WIDTH'($urandom), (1 << CNT_W) - 1, 1'b0);

        // random requests
        for (int i = 0; i < 15; i++)
            run_frame(WIDTH'($urandom), int'($urandom_range(1, 5)), bit'($urandom_range(0, 1)));

        repeat (3) @(posedge clk);
        #1;
        check_int("final_bits_empty", exp_bits.size(), 0);
        check_int("final_done_empty", exp_done.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seq_gen_1010.md
SEQ_GEN_1010 -- requirements
Module: seq_gen_1010

Interface
REQ-001 SHALL have parameter WIDTH, default 4, frame length in bits.
REQ-002 SHALL have parameter CNT_W, default 4, width of the repetition count.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the falling edge.
REQ-004 SHALL have port clr, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request to transmit; sampled on the falling edge of clk.
REQ-006 SHALL have port pattern, input, WIDTH, frame to send, MSB first; the intended value is 4'b1010.
REQ-007 SHALL have port reps, input, CNT_W, number of back-to-back frames to send.
REQ-008 SHALL have port out, output, 1, registered serial data.
REQ-009 SHALL have port valid, output, 1, high while out carries a pattern bit.
REQ-010 SHALL have port busy, output, 1, high in any non-IDLE state.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.

Function
REQ-012 SHALL implement the states IDLE, SHIFT and DONE, plus PRE when SEQ_GEN_PREAMBLE_EN is defined.
REQ-013 In IDLE with start=1 and reps!=0, a falling edge SHALL latch pattern and reps and enter SHIFT (or PRE when enabled).
REQ-014 In IDLE with start=1 and reps=0, the block SHALL ignore the request: remain in IDLE with busy=0 and no done pulse.
REQ-015 In SHIFT, out SHALL present one bit per clock, MSB first, with valid=1.
REQ-016 The first bit SHALL appear at the accepting edge (latency 0 cycles after that edge).
REQ-017 Frames SHALL be sent back-to-back with no gap, reloading the latched pattern after bit 0 of each frame.
REQ-018 After exactly WIDTH*reps bits, the FSM SHALL enter DONE with done=1, valid=0 and out=0 for one cycle, then return to IDLE.
REQ-019 start SHALL be ignored in SHIFT, PRE and DONE.
REQ-020 pattern and reps SHALL be ignored in SHIFT, PRE and DONE; changes to them in those states SHALL NOT affect the transfer in progress.
REQ-021 The bit counter SHALL be sized to hold WIDTH*(2^CNT_W-1) without overflow.
REQ-022 out SHALL be 0 whenever valid=0.

Reset
REQ-023 clr=1 at a falling edge SHALL force IDLE with out=0, valid=0, busy=0 and done=0 in every state, including mid-frame.
REQ-024 An aborted transfer SHALL produce no done pulse.
REQ-025 clr SHALL take priority over start at the same edge.

Configuration
REQ-026 With SEQ_GEN_PREAMBLE_EN defined, acceptance SHALL enter PRE for 2 cycles (out=0, valid=0, busy=1) before SHIFT, so that a downstream detector is guaranteed to start from its idle state.
REQ-027 With SEQ_GEN_PREAMBLE_EN defined, the first pattern bit SHALL therefore appear 2 cycles after the accepting edge.
REQ-028 Without SEQ_GEN_PREAMBLE_EN, the PRE state and its counter SHALL NOT exist.

Structure
REQ-029 Package seq_gen_pkg SHALL hold the state encoding constants, the default pattern 4'b1010, and PRE_LEN=2.
REQ-030 Sub-module seq_gen_shreg SHALL provide the loadable WIDTH-bit MSB-first shift register (load, shift, msb output).
REQ-031 The FSM and counters SHALL reside in seq_gen_1010.

Verification
REQ-032 reps=1, pattern=1010, start pulse -> out=1,0,1,0 on 4 consecutive edges with valid=1, then done=1 for one cycle.
REQ-033 reps=3, pattern=1010 -> 12 contiguous bits 101010101010; fed to a 1010 detector, the bench SHALL record exactly 3 detections; done fires once.
REQ-034 reps=0 with start=1 -> busy, valid and done stay 0 for 10 cycles.
REQ-035 clr asserted after bit 2 of a reps=2 transfer -> next edge IDLE, out=0, no done; a new start is then accepted normally.
REQ-036 start held high and pattern changed to 0110 during a transfer -> the transfer completes with 1010 unaltered and no restart.
REQ-037 SEQ_GEN_PREAMBLE_EN defined, reps=1 -> out 0,0 with valid=0, then 1,0,1,0 with valid=1, then done.
